// File: rtl/pioneer_ctrl_pkg.sv
// Shared control constants for the RW-Pioneer fetch sequencer: state codes,
// special opcodes and memory micro-instruction encodings.
package pioneer_ctrl_pkg;

   localparam int STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
   localparam logic [STATE_W-1:0] ST_FETCH   = 3'd1;
   localparam logic [STATE_W-1:0] ST_DECODE  = 3'd2;
   localparam logic [STATE_W-1:0] ST_OPERAND = 3'd3;
   localparam logic [STATE_W-1:0] ST_EXECUTE = 3'd4;
   localparam logic [STATE_W-1:0] ST_HALTED  = 3'd5;
   localparam logic [STATE_W-1:0] ST_PAUSE   = 3'd6;

   localparam logic [3:0] OP_HLT  = 4'hD;
   localparam logic [3:0] OP_SJMP = 4'hE;
   localparam logic [3:0] OP_JMP  = 4'hF;

   localparam int MEM_MICRO_INSTRUCTION_SIZE = 2;
   localparam logic [MEM_MICRO_INSTRUCTION_SIZE-1:0] MEM_NOP  = 2'd0;
   localparam logic [MEM_MICRO_INSTRUCTION_SIZE-1:0] MEM_SJMP = 2'd1;
   localparam logic [MEM_MICRO_INSTRUCTION_SIZE-1:0] MEM_JMP  = 2'd2;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Control/memory bundle between the fetch sequencer and the rest of the core.
// The step input exists only when SINGLE_STEP_EN is defined.
interface fetch_sequencer_if
   import pioneer_ctrl_pkg::*;
#(
   parameter int WORD_SIZE  = 4,
   parameter int MICRO_SIZE = MEM_MICRO_INSTRUCTION_SIZE
);
   logic                  run;
   logic [WORD_SIZE-1:0]  opcode;
   logic                  mem_ack;
   logic                  mem_req;
   logic                  ir_load;
   logic                  opnd_load;
   logic                  pc_ce;
   logic                  pc_halt;
   logic [MICRO_SIZE-1:0] mem_instruction;
   logic                  halted;
   logic [STATE_W-1:0]    state;
`ifdef SINGLE_STEP_EN
   logic                  step;

   modport master (
      input  run, opcode, mem_ack, step,
      output mem_req, ir_load, opnd_load, pc_ce, pc_halt, mem_instruction, halted, state
   );
   modport slave (
      output run, opcode, mem_ack, step,
      input  mem_req, ir_load, opnd_load, pc_ce, pc_halt, mem_instruction, halted, state
   );
`else
   modport master (
      input  run, opcode, mem_ack,
      output mem_req, ir_load, opnd_load, pc_ce, pc_halt, mem_instruction, halted, state
   );
   modport slave (
      output run, opcode, mem_ack,
      input  mem_req, ir_load, opnd_load, pc_ce, pc_halt, mem_instruction, halted, state
   );
`endif
endinterface

// File: rtl/fetch_sequencer_opcode_decoder.sv
// Combinational classification of the latched opcode into halt / operand-fetch
// / memory micro-instruction.
module opcode_decoder
   import pioneer_ctrl_pkg::*;
#(
   parameter int WORD_SIZE  = 4,
   parameter int MICRO_SIZE = MEM_MICRO_INSTRUCTION_SIZE
)(
   input  logic [WORD_SIZE-1:0]  opcode,
   output logic                  is_halt,
   output logic                  needs_operand,
   output logic [MICRO_SIZE-1:0] micro_op
);

   // Opcode classification table
   always_comb begin
      is_halt       = 1'b0;
      needs_operand = 1'b0;
      micro_op      = MICRO_SIZE'(MEM_NOP);
      case (opcode)
         WORD_SIZE'(OP_HLT): begin
            is_halt = 1'b1;
         end
         WORD_SIZE'(OP_SJMP): begin
            needs_operand = 1'b1;
            micro_op      = MICRO_SIZE'(MEM_SJMP);
         end
         WORD_SIZE'(OP_JMP): begin
            needs_operand = 1'b1;
            micro_op      = MICRO_SIZE'(MEM_JMP);
         end
         default: begin
            is_halt       = 1'b0;
            needs_operand = 1'b0;
            micro_op      = MICRO_SIZE'(MEM_NOP);
         end
      endcase
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch/decode/operand/execute control FSM and sole source of PC control.
// Optional SINGLE_STEP_EN adds a step input and a PAUSE state after EXECUTE.
module fetch_sequencer
   import pioneer_ctrl_pkg::*;
#(
   parameter int WORD_SIZE  = 4,
   parameter int MICRO_SIZE = MEM_MICRO_INSTRUCTION_SIZE
)(
   input  logic              clk,
   input  logic              reset,
   fetch_sequencer_if.master bus
);

   logic [STATE_W-1:0]    state_r;
   logic [STATE_W-1:0]    state_nx_s;
   logic                  run_q_r;
   logic                  run_pulse_s;
   logic [WORD_SIZE-1:0]  ir_r;
   logic                  is_halt_s;
   logic                  needs_opnd_s;
   logic [MICRO_SIZE-1:0] micro_op_s;
   logic                  fetch_ack_s;
   logic                  opnd_ack_s;

   assign run_pulse_s = bus.run & ~run_q_r;
   assign fetch_ack_s = (state_r == ST_FETCH)   & bus.mem_ack;
   assign opnd_ack_s  = (state_r == ST_OPERAND) & bus.mem_ack;

   opcode_decoder #(
      .WORD_SIZE  (WORD_SIZE),
      .MICRO_SIZE (MICRO_SIZE)
   ) u_opcode_decoder (
      .opcode        (ir_r),
      .is_halt       (is_halt_s),
      .needs_operand (needs_opnd_s),
      .micro_op      (micro_op_s)
   );

`ifdef SINGLE_STEP_EN
   logic step_q_r;
   logic step_pulse_s;
   logic ss_mode_r;

   assign step_pulse_s = bus.step & ~step_q_r;

   // Step edge detector; a run pulse in PAUSE drops single-step mode until reset
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         step_q_r  <= 1'b0;
         ss_mode_r <= 1'b1;
      end else begin
         step_q_r <= bus.step;
         if ((state_r == ST_PAUSE) && run_pulse_s) begin
            ss_mode_r <= 1'b0;
         end
      end
   end
`endif

   // State, run edge detector and private copy of the fetched opcode
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         run_q_r <= 1'b0;
         ir_r    <= '0;
      end else begin
         state_r <= state_nx_s;
         run_q_r <= bus.run;
         if (fetch_ack_s) begin
            ir_r <= bus.opcode;
         end
      end
   end

   // Next-state logic
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (run_pulse_s) state_nx_s = ST_FETCH;
            else             state_nx_s = ST_IDLE;
         end
         ST_FETCH: begin
            if (bus.mem_ack) state_nx_s = ST_DECODE;
            else             state_nx_s = ST_FETCH;
         end
         ST_DECODE: begin
            if (is_halt_s)         state_nx_s = ST_HALTED;
            else if (needs_opnd_s) state_nx_s = ST_OPERAND;
            else                   state_nx_s = ST_EXECUTE;
         end
         ST_OPERAND: begin
            if (bus.mem_ack) state_nx_s = ST_EXECUTE;
            else             state_nx_s = ST_OPERAND;
         end
         ST_EXECUTE: begin
`ifdef SINGLE_STEP_EN
            if (ss_mode_r) state_nx_s = ST_PAUSE;
            else           state_nx_s = ST_FETCH;
`else
            state_nx_s = ST_FETCH;
`endif
         end
         ST_HALTED: begin
            if (run_pulse_s) state_nx_s = ST_FETCH;
            else             state_nx_s = ST_HALTED;
         end
`ifdef SINGLE_STEP_EN
         ST_PAUSE: begin
            if (run_pulse_s || step_pulse_s) state_nx_s = ST_FETCH;
            else                             state_nx_s = ST_PAUSE;
         end
`endif
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // pc_ce only fires on memory-ack cycles, so it can never meet a jump micro-op
   assign bus.mem_req         = (state_r == ST_FETCH) | (state_r == ST_OPERAND);
   assign bus.ir_load         = fetch_ack_s;
   assign bus.opnd_load       = opnd_ack_s;
   assign bus.pc_ce           = fetch_ack_s | opnd_ack_s;
   assign bus.pc_halt         = (state_r == ST_IDLE) | (state_r == ST_HALTED) | (state_r == ST_PAUSE);
   assign bus.halted          = (state_r == ST_HALTED);
   assign bus.mem_instruction = (state_r == ST_EXECUTE) ? micro_op_s : MICRO_SIZE'(MEM_NOP);
   assign bus.state           = state_r;

endmodule
